// File: rtl/cpu_bus_bridge_if.sv
// Bus bundle between one CPU external-bus port and its shared-memory port.
// The slave modport is the bridge; the master modport is the CPU/memory side.
interface cpu_bus_bridge_if #(
  parameter int ADDR_W = 22
);
  logic              cpu_cs_n;
  logic              cpu_we_n;
  logic              cpu_oe_n;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_ta_n;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              busy;
  logic              err;

  modport slave (
    input  cpu_cs_n, cpu_we_n, cpu_oe_n, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_rdata, cpu_ta_n, mem_addr, mem_re, mem_we, mem_wdata, busy, err
  );

  modport master (
    output cpu_cs_n, cpu_we_n, cpu_oe_n, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_rdata, cpu_ta_n, mem_addr, mem_re, mem_we, mem_wdata, busy, err
  );
endinterface

// File: rtl/cpu_bus_bridge.sv
// Turns an asynchronous CPU chip-select cycle into one mem_re/mem_we strobe
// and returns read data plus transfer acknowledge once the read path settles.
module cpu_bus_bridge #(
  parameter int ADDR_W      = 22,
  parameter int RD_LAT      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  cpu_bus_bridge_if.slave bus
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RD_WAIT,
    ST_ACK,
    ST_RELEASE
  } state_t;

  state_t              state_reg;
  logic [SYNC_STAGES-1:0] cs_sync_reg, we_sync_reg, oe_sync_reg;
  logic                cs_s, we_s, oe_s;
  logic [CNT_W-1:0]    lat_cnt_reg;
  logic                abort_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [31:0]         mem_wdata_reg;
  logic [31:0]         cpu_rdata_reg;
  logic                mem_re_reg, mem_we_reg, cpu_ta_n_reg, busy_reg, err_reg;

  // Idle level of every strobe is 1, so the chains reset to 1 to avoid a phantom access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_reg <= '1;
      we_sync_reg <= '1;
      oe_sync_reg <= '1;
    end else begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        cs_sync_reg[i] <= cs_sync_reg[i-1];
        we_sync_reg[i] <= we_sync_reg[i-1];
        oe_sync_reg[i] <= oe_sync_reg[i-1];
      end
      cs_sync_reg[0] <= bus.cpu_cs_n;
      we_sync_reg[0] <= bus.cpu_we_n;
      oe_sync_reg[0] <= bus.cpu_oe_n;
    end
  end

  assign cs_s = cs_sync_reg[SYNC_STAGES-1];
  assign we_s = we_sync_reg[SYNC_STAGES-1];
  assign oe_s = oe_sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      lat_cnt_reg   <= '0;
      abort_reg     <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      cpu_rdata_reg <= '0;
      mem_re_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      cpu_ta_n_reg  <= 1'b1;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      mem_re_reg <= 1'b0;
      mem_we_reg <= 1'b0;
      err_reg    <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (!cs_s) begin
            if (!we_s && !oe_s) begin
              err_reg   <= 1'b1;
              busy_reg  <= 1'b1;
              state_reg <= ST_RELEASE;
            end else if (!we_s) begin
              mem_addr_reg  <= bus.cpu_addr;
              mem_wdata_reg <= bus.cpu_wdata;
              mem_we_reg    <= 1'b1;
              busy_reg      <= 1'b1;
              state_reg     <= ST_WRITE;
            end else if (!oe_s) begin
              mem_addr_reg <= bus.cpu_addr;
              mem_re_reg   <= 1'b1;
              abort_reg    <= 1'b0;
              busy_reg     <= 1'b1;
              state_reg    <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
          if (cs_s) begin
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            cpu_ta_n_reg <= 1'b0;
            state_reg    <= ST_ACK;
          end
        end
        ST_READ: begin
          lat_cnt_reg <= CNT_W'(RD_LAT - 1);
          abort_reg   <= cs_s;
          state_reg   <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          // An aborted read still captures its data; it only skips the acknowledge.
          if (lat_cnt_reg == '0) begin
            cpu_rdata_reg <= bus.mem_rdata;
            if (abort_reg || cs_s) begin
              busy_reg  <= 1'b0;
              state_reg <= ST_IDLE;
            end else begin
              cpu_ta_n_reg <= 1'b0;
              state_reg    <= ST_ACK;
            end
          end else begin
            lat_cnt_reg <= lat_cnt_reg - CNT_W'(1);
            if (cs_s) abort_reg <= 1'b1;
          end
        end
        ST_ACK: begin
          if (cs_s) begin
            cpu_ta_n_reg <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= ST_IDLE;
          end
        end
        ST_RELEASE: begin
          if (cs_s) begin
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          cpu_ta_n_reg <= 1'b1;
          busy_reg     <= 1'b0;
          state_reg    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.mem_re    = mem_re_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.cpu_rdata = cpu_rdata_reg;
  assign bus.cpu_ta_n  = cpu_ta_n_reg;
  assign bus.busy      = busy_reg;
  assign bus.err       = err_reg;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Directed bench for cpu_bus_bridge: write, read, protocol error, abort,
// held chip select and reset in the middle of a read.
module tb_cpu_bus_bridge;

  localparam int ADDR_W      = 22;
  localparam int RD_LAT      = 2;
  localparam int SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_bus_bridge_if #(.ADDR_W(ADDR_W)) bus_if ();

  cpu_bus_bridge #(
    .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  // Two-stage memory read path: RAM register then output register.
  logic [31:0] ram_q = 32'h0;
  function automatic logic [31:0] mem_model(input logic [ADDR_W-1:0] a);
    return (a == 22'h2200) ? 32'h12345678 : {10'h0, a};
  endfunction
  initial bus_if.mem_rdata = 32'h0;
  always @(posedge clk) begin
    if (bus_if.mem_re) ram_q <= mem_model(bus_if.mem_addr);
    bus_if.mem_rdata <= ram_q;
  end

  // Event counters sampled on the falling edge.
  int re_cnt = 0, we_cnt = 0, err_cnt = 0, ta_fall_cnt = 0, overlap_cnt = 0;
  logic ta_prev = 1'b1;
  always @(negedge clk) begin
    if (bus_if.mem_re) re_cnt++;
    if (bus_if.mem_we) we_cnt++;
    if (bus_if.err) err_cnt++;
    if (bus_if.mem_re && bus_if.mem_we) overlap_cnt++;
    if (ta_prev && !bus_if.cpu_ta_n) ta_fall_cnt++;
    ta_prev = bus_if.cpu_ta_n;
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // which: 0 ta low, 1 ta high, 2 mem_re, 3 mem_we, 4 err. n = -1 on timeout.
  task automatic wait_for(input int which, input int limit, output int n);
    logic hit;
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      case (which)
        0:       hit = !bus_if.cpu_ta_n;
        1:       hit = bus_if.cpu_ta_n;
        2:       hit = bus_if.mem_re;
        3:       hit = bus_if.mem_we;
        default: hit = bus_if.err;
      endcase
      if (hit) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  task automatic cpu_release();
    bus_if.cpu_cs_n = 1'b1;
    bus_if.cpu_we_n = 1'b1;
    bus_if.cpu_oe_n = 1'b1;
  endtask

  initial begin
    int n;
    int re0, we0, err0, ta0;

    bus_if.cpu_cs_n  = 1'b1;
    bus_if.cpu_we_n  = 1'b1;
    bus_if.cpu_oe_n  = 1'b1;
    bus_if.cpu_addr  = '0;
    bus_if.cpu_wdata = '0;

    // Reset state
    idle_cycles(3);
    chk1("rst_ta_n", bus_if.cpu_ta_n, 1'b1);
    chk1("rst_mem_re", bus_if.mem_re, 1'b0);
    chk1("rst_mem_we", bus_if.mem_we, 1'b0);
    chk1("rst_busy", bus_if.busy, 1'b0);
    chk1("rst_err", bus_if.err, 1'b0);
    chk32("rst_mem_addr", 32'(bus_if.mem_addr), 32'h0);
    chk32("rst_mem_wdata", bus_if.mem_wdata, 32'h0);
    chk32("rst_cpu_rdata", bus_if.cpu_rdata, 32'h0);
    rst_n = 1'b1;
    idle_cycles(3);
    $display("reset: outputs idle after release");

    // Write
    re0 = re_cnt; we0 = we_cnt; ta0 = ta_fall_cnt;
    bus_if.cpu_addr  = 22'h2004;
    bus_if.cpu_wdata = 32'hDEADBEEF;
    bus_if.cpu_cs_n  = 1'b0;
    bus_if.cpu_we_n  = 1'b0;
    wait_for(3, 10, n);
    chk1("wr_we_seen", n != -1, 1'b1);
    chk32("wr_mem_addr", 32'(bus_if.mem_addr), 32'h2004);
    chk32("wr_mem_wdata", bus_if.mem_wdata, 32'hDEADBEEF);
    chk1("wr_no_re", bus_if.mem_re, 1'b0);
    @(negedge clk);
    chk1("wr_we_one_cycle", bus_if.mem_we, 1'b0);
    chk1("wr_ta_low_next", bus_if.cpu_ta_n, 1'b0);
    chk1("wr_busy", bus_if.busy, 1'b1);
    idle_cycles(2);
    cpu_release();
    wait_for(1, 10, n);
    chk1("wr_ta_rise_seen", n != -1, 1'b1);
    chk1("wr_ta_rise_bound", n <= SYNC_STAGES + 1, 1'b1);
    chk1("wr_busy_clear", bus_if.busy, 1'b0);
    chkn("wr_we_pulses", we_cnt - we0, 1);
    chkn("wr_re_pulses", re_cnt - re0, 0);
    chkn("wr_acks", ta_fall_cnt - ta0, 1);
    $display("write: addr=%h data=%h ack after cs release in %0d cycles", 22'h2004, 32'hDEADBEEF, n);
    idle_cycles(3);

    // Read
    re0 = re_cnt; ta0 = ta_fall_cnt;
    bus_if.cpu_addr = 22'h2200;
    bus_if.cpu_cs_n = 1'b0;
    bus_if.cpu_oe_n = 1'b0;
    wait_for(2, 10, n);
    chk1("rd_re_seen", n != -1, 1'b1);
    chk32("rd_mem_addr", 32'(bus_if.mem_addr), 32'h2200);
    wait_for(0, 10, n);
    chkn("rd_ta_latency", n, RD_LAT + 1);
    chk32("rd_cpu_rdata", bus_if.cpu_rdata, 32'h12345678);
    cpu_release();
    wait_for(1, 10, n);
    chk1("rd_ta_rise_seen", n != -1, 1'b1);
    chkn("rd_re_pulses", re_cnt - re0, 1);
    chkn("rd_acks", ta_fall_cnt - ta0, 1);
    $display("read: addr=%h data=%h", 22'h2200, bus_if.cpu_rdata);
    idle_cycles(3);

    // Protocol error
    re0 = re_cnt; we0 = we_cnt; err0 = err_cnt; ta0 = ta_fall_cnt;
    bus_if.cpu_addr = 22'h2100;
    bus_if.cpu_cs_n = 1'b0;
    bus_if.cpu_we_n = 1'b0;
    bus_if.cpu_oe_n = 1'b0;
    wait_for(4, 10, n);
    chk1("err_seen", n != -1, 1'b1);
    @(negedge clk);
    chk1("err_one_cycle", bus_if.err, 1'b0);
    idle_cycles(4);
    chk1("err_ta_high", bus_if.cpu_ta_n, 1'b1);
    chk1("err_busy_hold", bus_if.busy, 1'b1);
    cpu_release();
    idle_cycles(4);
    chk1("err_busy_clear", bus_if.busy, 1'b0);
    chkn("err_pulses", err_cnt - err0, 1);
    chkn("err_no_strobe", (re_cnt - re0) + (we_cnt - we0), 0);
    chkn("err_no_ack", ta_fall_cnt - ta0, 0);
    $display("error: we_n and oe_n together, one err pulse");
    idle_cycles(2);

    // Abort a read right after its strobe, then a normal write
    re0 = re_cnt; ta0 = ta_fall_cnt;
    bus_if.cpu_addr = 22'h2300;
    bus_if.cpu_cs_n = 1'b0;
    bus_if.cpu_oe_n = 1'b0;
    wait_for(2, 10, n);
    chk1("ab_re_seen", n != -1, 1'b1);
    cpu_release();
    idle_cycles(8);
    chkn("ab_no_ack", ta_fall_cnt - ta0, 0);
    chk1("ab_busy_clear", bus_if.busy, 1'b0);
    chkn("ab_re_pulses", re_cnt - re0, 1);
    chk32("ab_rdata_updated", bus_if.cpu_rdata, 32'h00002300);
    $display("abort: read at %h dropped without ack", 22'h2300);

    we0 = we_cnt; ta0 = ta_fall_cnt;
    bus_if.cpu_addr  = 22'h2008;
    bus_if.cpu_wdata = 32'hCAFEF00D;
    bus_if.cpu_cs_n  = 1'b0;
    bus_if.cpu_we_n  = 1'b0;
    wait_for(3, 10, n);
    chk1("ab_wr_we_seen", n != -1, 1'b1);
    chk32("ab_wr_addr", 32'(bus_if.mem_addr), 32'h2008);
    chk32("ab_wr_wdata", bus_if.mem_wdata, 32'hCAFEF00D);
    wait_for(0, 10, n);
    chk1("ab_wr_ack", n != -1, 1'b1);
    cpu_release();
    wait_for(1, 10, n);
    chkn("ab_wr_acks", ta_fall_cnt - ta0, 1);
    $display("write after abort: addr=%h data=%h", 22'h2008, 32'hCAFEF00D);
    idle_cycles(3);

    // Chip select held low for 20 cycles
    we0 = we_cnt; ta0 = ta_fall_cnt;
    bus_if.cpu_addr  = 22'h2010;
    bus_if.cpu_wdata = 32'h55AA55AA;
    bus_if.cpu_cs_n  = 1'b0;
    bus_if.cpu_we_n  = 1'b0;
    idle_cycles(20);
    chkn("hold_we_pulses", we_cnt - we0, 1);
    chkn("hold_acks", ta_fall_cnt - ta0, 1);
    chk1("hold_ta_low", bus_if.cpu_ta_n, 1'b0);
    cpu_release();
    idle_cycles(4);
    chk1("hold_ta_high", bus_if.cpu_ta_n, 1'b1);
    $display("held cs: one write at %h", 22'h2010);
    idle_cycles(2);

    // Reset in the middle of a read
    bus_if.cpu_addr = 22'h2200;
    bus_if.cpu_cs_n = 1'b0;
    bus_if.cpu_oe_n = 1'b0;
    wait_for(2, 10, n);
    chk1("mr_re_seen", n != -1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mr_re_clear", bus_if.mem_re, 1'b0);
    chk1("mr_busy_clear", bus_if.busy, 1'b0);
    chk1("mr_ta_high", bus_if.cpu_ta_n, 1'b1);
    chk32("mr_mem_addr", 32'(bus_if.mem_addr), 32'h0);
    chk32("mr_cpu_rdata", bus_if.cpu_rdata, 32'h0);
    cpu_release();
    idle_cycles(2);
    re0 = re_cnt; we0 = we_cnt; ta0 = ta_fall_cnt;
    rst_n = 1'b1;
    idle_cycles(6);
    chkn("mr_no_residual", (re_cnt - re0) + (we_cnt - we0) + (ta_fall_cnt - ta0), 0);
    chk1("mr_idle", bus_if.busy, 1'b0);
    $display("reset mid-read: outputs cleared, no residual strobe");

    chkn("never_re_and_we", overlap_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
